// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus transfer sequencer: op codes and FSM states.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    OP_MOVE = 2'b00,
    OP_LOAD = 2'b01,
    OP_READ = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LATCH,
    DONE
  } state_t;

endpackage

// File: rtl/reg_bus_dec.sv
// One-hot decoder: drives vec[idx] high when en is set, all zeros otherwise.
module reg_bus_dec #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  vec
);

  always_comb begin
    vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      vec[i] = en && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/reg_bus_ctrl.sv
// Transfer sequencer for a shared tri-state register bus (MOVE / LOAD / READ).
// Optional transfer/error counters enabled by defining REG_BUS_XFER_CNT_EN.
module reg_bus_ctrl
  import reg_bus_pkg::*;
#(
  parameter int  NREG = 4,
  parameter int  W    = 4,
  localparam int IW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [IW-1:0]   req_src,
  input  logic [IW-1:0]   req_dst,
  input  logic [W-1:0]    req_data,
  input  logic [W-1:0]    bus_in,
  output logic [NREG-1:0] oen,
  output logic [NREG-1:0] inen,
  output logic            ext_drv_en,
  output logic [W-1:0]    ext_drv_data,
  output logic [W-1:0]    rd_data,
  output logic            done,
  output logic            err
`ifdef REG_BUS_XFER_CNT_EN
  ,
  output logic [7:0]      xfer_cnt,
  output logic [7:0]      err_cnt
`endif
);

  state_t        state, state_nx;
  op_t           op_q;
  logic [IW-1:0] src_q, dst_q;
  logic [W-1:0]  data_q;
  logic          err_q;
  logic          req_bad;
  logic          accept;
  logic          oen_en, inen_en;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    req_bad = (req_op == OP_RSVD)
           || ((req_op != OP_LOAD) && (int'(req_src) >= NREG))
           || ((req_op != OP_READ) && (int'(req_dst) >= NREG))
           || ((req_op == OP_MOVE) && (req_src == req_dst));
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = req_bad ? DONE : DRIVE;
      DRIVE:   state_nx = LATCH;
      LATCH:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_q   <= OP_MOVE;
      src_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      op_q   <= op_t'(req_op);
      src_q  <= req_src;
      dst_q  <= req_dst;
      data_q <= req_data;
      err_q  <= req_bad;
    end
  end

  // Enables decode only from the state register and latched fields, so clr drops them at once.
  assign oen_en       = ((state == DRIVE) || (state == LATCH)) && ((op_q == OP_MOVE) || (op_q == OP_READ));
  assign inen_en      = (state == LATCH) && ((op_q == OP_MOVE) || (op_q == OP_LOAD));
  assign ext_drv_en   = ((state == DRIVE) || (state == LATCH)) && (op_q == OP_LOAD);
  assign ext_drv_data = ext_drv_en ? data_q : '0;
  assign req_ready    = (state == IDLE);
  assign done         = (state == DONE);
  assign err          = (state == DONE) && err_q;

  reg_bus_dec #(.N(NREG), .IW(IW)) u_oen_dec (
    .idx (src_q),
    .en  (oen_en),
    .vec (oen)
  );

  reg_bus_dec #(.N(NREG), .IW(IW)) u_inen_dec (
    .idx (dst_q),
    .en  (inen_en),
    .vec (inen)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                                      rd_data <= '0;
    else if ((state == LATCH) && (op_q == OP_READ)) rd_data <= bus_in;
  end

`ifdef REG_BUS_XFER_CNT_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      xfer_cnt <= '0;
      err_cnt  <= '0;
    end else if (state == DONE) begin
      if (!err_q)                xfer_cnt <= xfer_cnt + 8'd1;
      else if (err_cnt != 8'hFF) err_cnt  <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Self-checking bench for reg_bus_ctrl with a behavioural register bank and transfer model.
module tb_reg_bus_ctrl;

  localparam int NREG = 4;
  localparam int W    = 4;

  localparam logic [1:0] MV = 2'b00;
  localparam logic [1:0] LD = 2'b01;
  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] RS = 2'b11;

  logic            clk = 1'b0;
  logic            clr;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [1:0]      req_src, req_dst;
  logic [W-1:0]    req_data;
  logic [W-1:0]    bus_in;
  logic [NREG-1:0] oen, inen;
  logic            ext_drv_en;
  logic [W-1:0]    ext_drv_data;
  logic [W-1:0]    rd_data;
  logic            done, err;
`ifdef REG_BUS_XFER_CNT_EN
  logic [7:0]      xfer_cnt, err_cnt;
`endif

  reg_bus_ctrl #(.NREG(NREG), .W(W)) dut (
    .clk          (clk),
    .clr          (clr),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_src      (req_src),
    .req_dst      (req_dst),
    .req_data     (req_data),
    .bus_in       (bus_in),
    .oen          (oen),
    .inen         (inen),
    .ext_drv_en   (ext_drv_en),
    .ext_drv_data (ext_drv_data),
    .rd_data      (rd_data),
    .done         (done),
    .err          (err)
`ifdef REG_BUS_XFER_CNT_EN
    ,
    .xfer_cnt     (xfer_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Register bank and bus resolution owned by the surrounding top level.
  logic         bank_rst;
  logic [W-1:0] bank [NREG];

  always_comb begin
    bus_in = '0;
    if (ext_drv_en) bus_in = ext_drv_data;
    for (int i = 0; i < NREG; i++) if (oen[i]) bus_in = bank[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (bank_rst)     bank[i] <= W'(i * 3 + 1);
      else if (inen[i]) bank[i] <= bus_in;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_reg [NREG];
  logic [W-1:0] m_rd;
  int           m_xfer, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_chk();
    logic bad;
    bad = (($countones(oen) + int'(ext_drv_en)) > 1) || ($countones(inen) > 1) || ((oen & inen) != '0);
    chk("bus_contention", 32'(bad), 32'd0);
  endtask

  function automatic logic is_bad(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst);
    return (op == RS) || ((op == MV) && (src == dst));
  endfunction

  task automatic model_apply(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                             input logic [3:0] data);
    if (is_bad(op, src, dst)) begin
      if (m_err < 255) m_err++;
    end else begin
      m_xfer = (m_xfer + 1) % 256;
      case (op)
        MV:      m_reg[dst] = m_reg[src];
        LD:      m_reg[dst] = data;
        default: m_rd = m_reg[src];
      endcase
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic run_req(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                         input logic [3:0] data, input logic exp_err);
    int           ncyc;
    logic         drv;
    logic [3:0]   eo, ei;
    wait_ready();
    req_op = op; req_src = src; req_dst = dst; req_data = data; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    ncyc = exp_err ? 1 : 3;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      bus_chk();
      drv = !exp_err && (c < 3);
      eo  = (drv && (op != LD)) ? (4'b0001 << src) : 4'b0000;
      ei  = (!exp_err && (c == 2) && (op != RD)) ? (4'b0001 << dst) : 4'b0000;
      chk("oen", 32'(oen), 32'(eo));
      chk("inen", 32'(inen), 32'(ei));
      chk("ext_drv_en", 32'(ext_drv_en), 32'(drv && (op == LD)));
      if (drv && (op == LD)) chk("ext_drv_data", 32'(ext_drv_data), 32'(data));
      chk("done", 32'(done), 32'(c == ncyc));
      chk("err", 32'(err), 32'((c == ncyc) && exp_err));
      chk("busy_not_ready", 32'(req_ready), 32'd0);
    end
    model_apply(op, src, dst, data);
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    if (!exp_err && (op != RD)) chk("bank_dst", 32'(bank[dst]), 32'(m_reg[dst]));
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
`ifdef REG_BUS_XFER_CNT_EN
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_xfer));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
  endtask

  typedef struct {
    logic [1:0] op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [3:0] data;
    logic       exp_err;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] b_op [3];
    logic [1:0] b_src [3];
    logic [1:0] b_dst [3];
    logic [3:0] b_dat [3];
    int         acc [3];
    int         idx, cyc, k;
    logic [1:0] rop, rsrc, rdst;
    logic [3:0] rdat;

    tbl[0] = '{LD, 2'd0, 2'd2, 4'hA, 1'b0, 4'h0};
    tbl[1] = '{RD, 2'd2, 2'd0, 4'h0, 1'b0, 4'hA};
    tbl[2] = '{MV, 2'd2, 2'd0, 4'h0, 1'b0, 4'h0};
    tbl[3] = '{RD, 2'd0, 2'd0, 4'h0, 1'b0, 4'hA};
    tbl[4] = '{MV, 2'd1, 2'd1, 4'h0, 1'b1, 4'h0};
    tbl[5] = '{RS, 2'd0, 2'd3, 4'h6, 1'b1, 4'h0};
    tbl[6] = '{LD, 2'd0, 2'd3, 4'h5, 1'b0, 4'h0};
    tbl[7] = '{MV, 2'd3, 2'd1, 4'h0, 1'b0, 4'h0};
    tbl[8] = '{RD, 2'd1, 2'd0, 4'h0, 1'b0, 4'h5};

    req_valid = 1'b0; req_op = '0; req_src = '0; req_dst = '0; req_data = '0;
    clr = 1'b1; bank_rst = 1'b1;
    for (int i = 0; i < NREG; i++) m_reg[i] = W'(i * 3 + 1);
    m_rd = '0; m_xfer = 0; m_err = 0;

    #1;
    chk("rst_oen", 32'(oen), 32'd0);
    chk("rst_inen", 32'(inen), 32'd0);
    chk("rst_ext_drv_en", 32'(ext_drv_en), 32'd0);
    chk("rst_ext_drv_data", 32'(ext_drv_data), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    clr = 1'b0; bank_rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 9; t++) begin
      run_req(tbl[t].op, tbl[t].src, tbl[t].dst, tbl[t].data, tbl[t].exp_err);
      if (tbl[t].op == RD && !tbl[t].exp_err) chk("tbl_rd_data", 32'(rd_data), 32'(tbl[t].exp_rd));
    end

    // Three requests queued with req_valid held high throughout.
    b_op[0] = LD; b_src[0] = 2'd0; b_dst[0] = 2'd1; b_dat[0] = 4'h7;
    b_op[1] = LD; b_src[1] = 2'd0; b_dst[1] = 2'd3; b_dat[1] = 4'h9;
    b_op[2] = RD; b_src[2] = 2'd1; b_dst[2] = 2'd0; b_dat[2] = 4'h0;
    for (int i = 0; i < 3; i++) acc[i] = 0;
    idx = 0; cyc = 0;
    req_op = b_op[0]; req_src = b_src[0]; req_dst = b_dst[0]; req_data = b_dat[0]; req_valid = 1'b1;
    for (int t = 0; t < 40 && idx < 3; t++) begin
      @(negedge clk);
      cyc++;
      bus_chk();
      if (req_ready) begin
        acc[idx] = cyc;
        @(posedge clk);
        #1;
        model_apply(b_op[idx], b_src[idx], b_dst[idx], b_dat[idx]);
        idx++;
        if (idx < 3) begin
          req_op = b_op[idx]; req_src = b_src[idx]; req_dst = b_dst[idx]; req_data = b_dat[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(idx), 32'd3);
    chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd4);
    chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd4);
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 10) begin
      bus_chk();
      @(negedge clk);
      k++;
    end
    chk("b2b_ready", 32'(req_ready), 32'd1);
    chk("b2b_rd_data", 32'(rd_data), 32'h7);
    chk("b2b_bank3", 32'(bank[3]), 32'h9);

    // clr asserted during LATCH of a LOAD aborts it with no completion.
    wait_ready();
    req_op = LD; req_src = 2'd0; req_dst = 2'd0; req_data = 4'hF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_latch_inen", 32'(inen), 32'b0001);
    #1 clr = 1'b1;
    #1;
    chk("abort_inen", 32'(inen), 32'd0);
    chk("abort_oen", 32'(oen), 32'd0);
    chk("abort_ext", 32'(ext_drv_en), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    m_rd = '0; m_xfer = 0; m_err = 0;
`ifdef REG_BUS_XFER_CNT_EN
    chk("abort_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    chk("abort_bank0", 32'(bank[0]), 32'(m_reg[0]));
    chk("abort_rd_data", 32'(rd_data), 32'd0);
    run_req(LD, 2'd0, 2'd2, 4'h3, 1'b0);
`ifdef REG_BUS_XFER_CNT_EN
    chk("post_abort_xfer_cnt", 32'(xfer_cnt), 32'd1);
`endif

    for (int t = 0; t < 60; t++) begin
      rop  = 2'($urandom_range(0, 3));
      rsrc = 2'($urandom_range(0, 3));
      rdst = 2'($urandom_range(0, 3));
      rdat = 4'($urandom_range(0, 15));
      run_req(rop, rsrc, rdst, rdat, is_bad(rop, rsrc, rdst));
    end
    for (int i = 0; i < NREG; i++) chk("final_bank", 32'(bank[i]), 32'(m_reg[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bus_ctrl.md
Name: reg_bus_ctrl

Overview:
- Transfer sequencer for a shared W-bit tri-state register bus built from 4-bit enable/output-enable registers.
- Accepts one transfer request at a time: register-to-register MOVE, external LOAD into a register, or READ of a register.
- Generates per-register output enables (oen) and input enables (inen), plus the external bus driver enable.
- Sits directly upstream of the register bank and drives its control pins; the top level owns the tri-state bus wiring.

Parameters:
- NREG, 4, number of registers on the bus (2..16).
- W, 4, bus and data width.
- IW (localparam), $clog2(NREG), register index width.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_op  in  2  operation: 00 MOVE, 01 LOAD, 10 READ, 11 reserved.
- req_src  in  IW  source register index (MOVE, READ).
- req_dst  in  IW  destination register index (MOVE, LOAD).
- req_data  in  W  data for LOAD.
- bus_in  in  W  resolved bus value, observed by the block.
- oen  out  NREG  per-register output enable, at most one bit high.
- inen  out  NREG  per-register input enable, at most one bit high.
- ext_drv_en  out  1  enables the external bus driver at the top level.
- ext_drv_data  out  W  value driven onto the bus when ext_drv_en is high.
- rd_data  out  W  result of the last READ.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done; request rejected, no enables asserted.

Behaviour:
- States: IDLE, DRIVE, LATCH, DONE.
- Reset: state=IDLE, oen=0, inen=0, ext_drv_en=0, ext_drv_data=0, rd_data=0, done=0, err=0, req_ready=1.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. The block registers op, src, dst and data, then goes to DRIVE.
- Invalid request: op=11, src/dst >= NREG, or MOVE with src==dst.
  - Skip DRIVE and LATCH; go straight to DONE with err=1.
  - oen, inen and ext_drv_en stay 0 throughout.
- DRIVE (1 cycle), bus settle:
  - MOVE/READ: oen[src]=1.
  - LOAD: ext_drv_en=1, ext_drv_data=data.
- LATCH (1 cycle):
  - Same drive enables as DRIVE are held.
  - MOVE/LOAD: inen[dst]=1, so the destination captures on the edge that ends LATCH.
  - READ: rd_data<=bus_in on the edge that ends LATCH.
- DONE (1 cycle): done=1, err per request; all enables 0; next state IDLE.
- Enables are registered outputs, decoded from state and registered fields; no combinational path from req_* to oen/inen.
- Latency: accept at edge N → done high in cycle N+3. Invalid request: done in cycle N+1. Throughput is 1 request per 4 cycles.
- Bus contention: ext_drv_en and any oen bit are never high together. oen and inen never name the same index.
- req_valid held while busy: ignored; the request stays pending until IDLE.
- clr mid-transfer: all enables drop immediately and state returns to IDLE. No done pulse is issued for the aborted request.
- rd_data changes only at completion of a valid READ; it holds otherwise.

Optional Feature:
- Macro: REG_BUS_XFER_CNT_EN.
- Defined:
  - Adds output xfer_cnt [7:0], reset 0.
  - Increments on each valid completion (done && !err) and wraps 255→0.
  - Adds output err_cnt [7:0], which increments on done && err and saturates at 255.
- Undefined: neither port nor counter exists.

Decomposition:
- Package reg_bus_pkg:
  - op encodings OP_MOVE=2'b00, OP_LOAD=2'b01, OP_READ=2'b10, OP_RSVD=2'b11.
  - state encoding IDLE/DRIVE/LATCH/DONE.
- One natural sub-module: reg_bus_dec, a one-hot decoder from index plus enable to an NREG-wide vector. It is instantiated twice, for oen and inen.

Test Plan:
- Reset: assert clr mid-sim → oen=0, inen=0, ext_drv_en=0, done=0, req_ready=1 immediately, without waiting for a clock edge.
- LOAD dst=2 data=4'hA, then READ src=2:
  - oen=0000 throughout the LOAD; inen=0100 in its LATCH cycle; ext_drv_en high for 2 cycles.
  - READ: rd_data=4'hA; done 3 cycles after each accept; err=0.
- MOVE src=2 dst=0 after the LOAD above, then READ src=0:
  - oen=0100 for 2 cycles; inen=0001 in LATCH.
  - READ returns 4'hA.
- MOVE src=1 dst=1 and op=11 → done with err=1 one cycle after accept; no oen, inen or ext_drv_en activity.
- Back-to-back req_valid held high with 3 queued requests → accepts spaced exactly 4 cycles apart; at most one bus driver at any time (contention assertion).
- clr pulsed during LATCH of a LOAD → inen drops at once, no done pulse; the next request completes normally. With REG_BUS_XFER_CNT_EN defined, xfer_cnt=0 after clr and =1 after that request.
